// File: rtl/hex_display_seq.sv
// rtl/hex_display_seq.sv - instruction/result hex display sequencer with hold and invalid-opcode blink
// Accepts one request in IDLE, holds ALU/MEM displays, blinks INVALID displays, flags dropped requests.
module hex_display_seq #(
   parameter int NUM_DIGITS  = 8,
   parameter int DATA_W      = 16,
   parameter int HOLD_CYCLES = 4,
   parameter int BLINK_DIV   = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    valid,
   output logic                    ready,
   input  logic [3:0]              codop,
   input  logic [15:0]             operando1,
   input  logic [15:0]             operando2,
   input  logic [15:0]             operando3,
   input  logic [DATA_W-1:0]       dado,
   output logic                    sinal,
   output logic [NUM_DIGITS-1:0]   modo,
   output logic [4*NUM_DIGITS-1:0] display,
   output logic                    dropped
);

   localparam int D    = DATA_W / 4;
   localparam int HC_W = $clog2(HOLD_CYCLES + 1);
   localparam int BC_W = $clog2(BLINK_DIV + 1);

   localparam logic [HC_W-1:0] HOLD_LOAD  = HC_W'(HOLD_CYCLES - 1);
   localparam logic [BC_W-1:0] BLINK_LOAD = BC_W'(BLINK_DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_BLINK = 2'd2;

   logic [1:0]              r_state;
   logic [HC_W-1:0]         r_hold_cnt;
   logic [BC_W-1:0]         r_blink_cnt;
   logic [1:0]              r_phase;
   logic [4*NUM_DIGITS-1:0] r_display;
   logic [NUM_DIGITS-1:0]   r_modo;
   logic                    r_sinal;
   logic                    r_dropped;

   logic [4*NUM_DIGITS-1:0] w_disp_alu;
   logic [4*NUM_DIGITS-1:0] w_disp_mem;
   logic [4*NUM_DIGITS-1:0] w_disp_inv;
   logic [NUM_DIGITS-1:0]   w_modo_alu;
   logic [NUM_DIGITS-1:0]   w_modo_mem;
   logic                    w_is_alu;
   logic                    w_is_mem;
   logic                    w_ready;
   logic                    w_unused_ops;

   // Only the low byte of each operand is ever shown.
   assign w_unused_ops = ^{operando1[15:8], operando2[15:8], operando3[15:8]};

   assign w_is_alu = (codop <= 4'd10);
   assign w_is_mem = (codop == 4'd11) || (codop == 4'd12);
   assign w_ready  = (r_state == S_IDLE);

   always_comb begin
      w_disp_alu                 = '0;
      w_disp_alu[4*D-1:0]        = dado;
      w_disp_alu[4*D +: 8]       = operando2[7:0];
      w_disp_alu[4*D+8 +: 8]     = operando1[7:0];

      w_disp_mem                 = '0;
      w_disp_mem[4*D +: 8]       = operando1[7:0];
      w_disp_mem[4*D+8 +: 8]     = operando3[7:0];

      w_disp_inv                 = '0;
      w_disp_inv[3:0]            = codop;
      w_disp_inv[4*NUM_DIGITS-1 -: 8] = 8'hEE;

      w_modo_alu = '0;
      w_modo_mem = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_modo_alu[i] = (i < D + 4);
         w_modo_mem[i] = (i >= D) && (i < D + 4);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_hold_cnt  <= '0;
         r_blink_cnt <= '0;
         r_phase     <= '0;
         r_display   <= '0;
         r_modo      <= '0;
         r_sinal     <= 1'b0;
         r_dropped   <= 1'b0;
      end else begin
         r_dropped <= valid && !w_ready;
         case (r_state)
            S_IDLE: begin
               if (valid) begin
                  if (w_is_alu) begin
                     r_display  <= w_disp_alu;
                     r_modo     <= w_modo_alu;
                     r_sinal    <= 1'b1;
                     r_hold_cnt <= HOLD_LOAD;
                     r_state    <= S_HOLD;
                  end else if (w_is_mem) begin
                     r_display  <= w_disp_mem;
                     r_modo     <= w_modo_mem;
                     r_sinal    <= 1'b0;
                     r_hold_cnt <= HOLD_LOAD;
                     r_state    <= S_HOLD;
                  end else begin
                     r_display   <= w_disp_inv;
                     r_modo      <= '1;
                     r_sinal     <= 1'b0;
                     r_blink_cnt <= BLINK_LOAD;
                     r_phase     <= 2'd0;
                     r_state     <= S_BLINK;
                  end
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt - HC_W'(1);
               end
            end
            S_BLINK: begin
               // Phases alternate on/off; the last one returns to a blank display.
               if (r_blink_cnt == '0) begin
                  if (r_phase == 2'd3) begin
                     r_display <= '0;
                     r_modo    <= '0;
                     r_sinal   <= 1'b0;
                     r_state   <= S_IDLE;
                  end else begin
                     r_phase     <= r_phase + 2'd1;
                     r_blink_cnt <= BLINK_LOAD;
                     r_modo      <= ~r_modo;
                  end
               end else begin
                  r_blink_cnt <= r_blink_cnt - BC_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready   = w_ready;
   assign display = r_display;
   assign modo    = r_modo;
   assign sinal   = r_sinal;
   assign dropped = r_dropped;

endmodule

// File: tb/tb_hex_display_seq.sv
// tb/tb_hex_display_seq.sv - scoreboard bench for hex_display_seq
// Stimulus pushes expected displays; a monitor pops them on every accept.
module tb_hex_display_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        valid;
   logic        ready;
   logic [3:0]  codop;
   logic [15:0] operando1, operando2, operando3;
   logic [15:0] dado;
   logic        sinal;
   logic [7:0]  modo;
   logic [31:0] display;
   logic        dropped;

   typedef struct packed {
      logic [31:0] d;
      logic [7:0]  m;
      logic        s;
   } exp_t;

   exp_t exp_q[$];
   int   acc_log[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   hex_display_seq dut (
      .clock     (clock),
      .reset     (reset),
      .valid     (valid),
      .ready     (ready),
      .codop     (codop),
      .operando1 (operando1),
      .operando2 (operando2),
      .operando3 (operando3),
      .dado      (dado),
      .sinal     (sinal),
      .modo      (modo),
      .display   (display),
      .dropped   (dropped)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total = total + 1;
      if (got !== want) begin
         bad = bad + 1;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Called right after a negedge: present a request for one cycle.
   task automatic send(input logic [3:0] c, input logic [15:0] o1, input logic [15:0] o2,
                       input logic [15:0] o3, input logic [15:0] dd, input exp_t e);
      codop = c; operando1 = o1; operando2 = o2; operando3 = o3; dado = dd;
      valid = 1'b1;
      exp_q.push_back(e);
      @(negedge clock);
      valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      logic acc;
      forever begin
         @(posedge clock);
         acc = valid && ready && !reset;
         cyc = cyc + 1;
         if (acc) begin
            acc_log.push_back(cyc);
            #1;
            total = total + 1;
            if (exp_q.size() == 0) begin
               bad = bad + 1;
               $display("FAIL unexpected_accept: got display=%h at cycle %0d want no accept", display, cyc);
            end else begin
               e = exp_q.pop_front();
               if (display !== e.d || modo !== e.m || sinal !== e.s) begin
                  bad = bad + 1;
                  $display("FAIL accept_out: got d=%h m=%h s=%b want d=%h m=%h s=%b (cycle %0d)",
                           display, modo, sinal, e.d, e.m, e.s, cyc);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timed out");
   end

   initial begin : stim
      int base;
      reset = 1'b1; valid = 1'b0; codop = '0;
      operando1 = '0; operando2 = '0; operando3 = '0; dado = '0;
      repeat (3) @(negedge clock);
      chk("rst_display", display, 32'h0);
      chk("rst_modo",    {24'h0, modo}, 32'h0);
      chk("rst_sinal",   {31'h0, sinal}, 32'h0);
      chk("rst_dropped", {31'h0, dropped}, 32'h0);
      chk("rst_ready",   {31'h0, ready}, 32'h1);
      reset = 1'b0;
      @(negedge clock);

      // ALU example; ready low for exactly HOLD_CYCLES cycles
      send(4'd3, 16'h12AB, 16'h0034, 16'h5555, 16'hBEEF, '{32'hAB34BEEF, 8'hFF, 1'b1});
      for (int k = 0; k < 4; k++) begin
         chk("alu_hold_ready", {31'h0, ready}, 32'h0);
         @(negedge clock);
      end
      chk("alu_idle_ready", {31'h0, ready}, 32'h1);
      chk("alu_display_kept", display, 32'hAB34BEEF);

      // Drop: valid pulse two cycles after accept
      send(4'd0, 16'h00CD, 16'h00EF, 16'h0000, 16'h0123, '{32'hCDEF0123, 8'hFF, 1'b1});
      @(negedge clock);
      codop = 4'd5; operando1 = 16'h0011; operando2 = 16'h0022; dado = 16'h9999;
      valid = 1'b1;
      @(negedge clock);
      valid = 1'b0;
      chk("drop_pulse",   {31'h0, dropped}, 32'h1);
      chk("drop_display", display, 32'hCDEF0123);
      @(negedge clock);
      chk("drop_clear",   {31'h0, dropped}, 32'h0);
      repeat (2) @(negedge clock);
      chk("drop_idle",    {31'h0, ready}, 32'h1);

      // MEM example
      send(4'd11, 16'h0056, 16'h00FF, 16'h0078, 16'h1234, '{32'h78560000, 8'hF0, 1'b0});
      repeat (4) @(negedge clock);
      chk("mem_idle_ready", {31'h0, ready}, 32'h1);
      chk("mem_display_kept", display, 32'h78560000);

      // INVALID: four blink phases of 8 cycles
      send(4'd14, 16'h1111, 16'h2222, 16'h3333, 16'h4444, '{32'hEE00000E, 8'hFF, 1'b0});
      for (int j = 0; j < 32; j++) begin
         chk("blink_modo", {24'h0, modo}, ((j / 8) % 2 == 0) ? 32'hFF : 32'h00);
         chk("blink_ready", {31'h0, ready}, 32'h0);
         @(negedge clock);
      end
      chk("blink_end_display", display, 32'h0);
      chk("blink_end_modo",    {24'h0, modo}, 32'h0);
      chk("blink_end_ready",   {31'h0, ready}, 32'h1);

      // Reset during blink phase 2
      send(4'd13, 16'h0000, 16'h0000, 16'h0000, 16'h0000, '{32'hEE00000D, 8'hFF, 1'b0});
      repeat (17) @(negedge clock);
      chk("rstblink_phase2_modo", {24'h0, modo}, 32'hFF);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rstblink_display", display, 32'h0);
      chk("rstblink_modo",    {24'h0, modo}, 32'h0);
      chk("rstblink_sinal",   {31'h0, sinal}, 32'h0);
      chk("rstblink_ready",   {31'h0, ready}, 32'h1);
      send(4'd10, 16'hFF99, 16'h0088, 16'h0000, 16'hCAFE, '{32'h9988CAFE, 8'hFF, 1'b1});
      repeat (4) @(negedge clock);
      chk("rstblink_after_ready", {31'h0, ready}, 32'h1);

      // Back-to-back with valid held high
      base = cyc;
      codop = 4'd1; operando1 = 16'hAB11; operando2 = 16'h0022; dado = 16'h3333;
      valid = 1'b1;
      exp_q.push_back('{32'h11223333, 8'hFF, 1'b1});
      @(negedge clock);
      codop = 4'd2; operando1 = 16'h0044; operando2 = 16'h0055; dado = 16'h6666;
      exp_q.push_back('{32'h44556666, 8'hFF, 1'b1});
      repeat (5) @(negedge clock);
      codop = 4'd9; operando1 = 16'h0077; operando2 = 16'hCD88; dado = 16'h9999;
      exp_q.push_back('{32'h77889999, 8'hFF, 1'b1});
      repeat (5) @(negedge clock);
      valid = 1'b0;
      if (acc_log.size() >= 3) begin
         chk("b2b_accept0", acc_log[acc_log.size()-3], base + 1);
         chk("b2b_accept1", acc_log[acc_log.size()-2], base + 6);
         chk("b2b_accept2", acc_log[acc_log.size()-1], base + 11);
      end else begin
         chk("b2b_accept_count", acc_log.size(), 3);
      end
      repeat (6) @(negedge clock);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("total_accepts", acc_log.size(), 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
